filter_mac_sequencer: RTL and testbench

Initiator and result collector for the filter MAC accumulator. It stores one kernel of signed fixed-point coefficients and accepts a pixel stream, one pixel per tap. For each tap it drives pixel, coefficient, enable and last-tap strobe into the MAC. After the last tap it captures the MAC's 32-bit sum, rounds and normalises it to an 8-bit pixel, and returns that pixel over a valid/ready interface.

---
 rtl/filter_mac_sequencer.sv | 106 ++++++++++
 tb/tb_filter_mac_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_mac_sequencer.sv
// Filter MAC sequencer: feeds one kernel of pixel/coefficient taps into the MAC, then rounds,
// saturates and returns the sum as one pixel. Define SEQ_ABSOLUTE_EN to output |t| instead of clamping negatives to 0.
module filter_mac_sequencer #(
  parameter int KERNEL_TAPS = 9,
  parameter int FRAC_BITS   = 10,
  parameter int PIXEL_WIDTH = 8,
  parameter int COEFF_WIDTH = 24,
  parameter int ACC_WIDTH   = 32,
  parameter int ADDR_WIDTH  = $clog2(KERNEL_TAPS)
) (
  input  logic                          clk,
  input  logic                          nreset,
  input  logic                          enable,
  input  logic                          coeff_wr_en,
  input  logic [ADDR_WIDTH-1:0]         coeff_wr_addr,
  input  logic signed [COEFF_WIDTH-1:0] coeff_wr_data,
  input  logic                          pix_valid,
  input  logic [PIXEL_WIDTH-1:0]        pix_data,
  output logic                          pix_ready,
  output logic [PIXEL_WIDTH-1:0]        mac_pixel,
  output logic signed [COEFF_WIDTH-1:0] mac_coeff,
  output logic                          mac_en,
  output logic                          mac_last,
  input  logic signed [ACC_WIDTH-1:0]   mac_result,
  output logic                          res_valid,
  output logic [PIXEL_WIDTH-1:0]        res_data,
  input  logic                          res_ready,
  output logic                          busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_OUT} state_t;

  localparam logic [ADDR_WIDTH-1:0]   LAST_TAP = ADDR_WIDTH'(KERNEL_TAPS - 1);
  localparam logic [ADDR_WIDTH:0]     NUM_TAPS = (ADDR_WIDTH + 1)'(KERNEL_TAPS);
  localparam logic signed [ACC_WIDTH:0] HALF   = {{ACC_WIDTH{1'b0}}, 1'b1} << (FRAC_BITS - 1);
  localparam logic signed [ACC_WIDTH:0] PIX_MAX =
    {{(ACC_WIDTH + 1 - PIXEL_WIDTH){1'b0}}, {PIXEL_WIDTH{1'b1}}};

  state_t                        state;
  logic [ADDR_WIDTH-1:0]         tap_cnt;
  logic signed [COEFF_WIDTH-1:0] coeff [KERNEL_TAPS];

  logic signed [ACC_WIDTH:0]     rounded;
  logic signed [ACC_WIDTH:0]     mag;
  logic [PIXEL_WIDTH-1:0]        norm;

  assign pix_ready = (state == S_RUN);
  assign mac_en    = pix_valid & pix_ready;
  assign mac_pixel = pix_data;
  assign mac_coeff = coeff[tap_cnt];
  assign mac_last  = mac_en & (tap_cnt == LAST_TAP);
  assign busy      = (state != S_IDLE);

  // One extra bit of headroom makes the half-LSB rounding add overflow-free.
  always_comb begin
    rounded = ($signed({mac_result[ACC_WIDTH-1], mac_result}) + HALF) >>> FRAC_BITS;
`ifdef SEQ_ABSOLUTE_EN
    mag = rounded[ACC_WIDTH] ? -rounded : rounded;
`else
    mag = rounded[ACC_WIDTH] ? '0 : rounded;
`endif
    norm = (mag > PIX_MAX) ? '1 : mag[PIXEL_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= S_IDLE;
      tap_cnt   <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      for (int unsigned i = 0; i < KERNEL_TAPS; i++) coeff[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (coeff_wr_en && ({1'b0, coeff_wr_addr} < NUM_TAPS))
            coeff[coeff_wr_addr] <= coeff_wr_data;
          if (enable) state <= S_RUN;
        end
        S_RUN: begin
          if (mac_en) begin
            if (tap_cnt == LAST_TAP) begin
              tap_cnt <= '0;
              state   <= S_WAIT;
            end else begin
              tap_cnt <= tap_cnt + ADDR_WIDTH'(1);
            end
          end
        end
        // MAC output register was loaded by the last-tap edge.
        S_WAIT: begin
          res_data  <= norm;
          res_valid <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= enable ? S_RUN : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_filter_mac_sequencer.sv
// Bench for filter_mac_sequencer: a behavioural MAC stand-in plus an arithmetic reference
// for the normalised output; honours SEQ_ABSOLUTE_EN like the design.
module tb_filter_mac_sequencer;
  localparam int TAPS = 9;
  localparam int FRAC = 10;
  localparam int PW   = 8;
  localparam int CW   = 24;
  localparam int AW   = 32;
  localparam int ADW  = $clog2(TAPS);

  typedef int arr_t [TAPS];

  logic                 clk = 1'b0;
  logic                 nreset = 1'b0;
  logic                 enable = 1'b0;
  logic                 coeff_wr_en = 1'b0;
  logic [ADW-1:0]       coeff_wr_addr = '0;
  logic signed [CW-1:0] coeff_wr_data = '0;
  logic                 pix_valid = 1'b0;
  logic [PW-1:0]        pix_data = '0;
  logic                 pix_ready;
  logic [PW-1:0]        mac_pixel;
  logic signed [CW-1:0] mac_coeff;
  logic                 mac_en;
  logic                 mac_last;
  logic signed [AW-1:0] mac_result;
  logic                 res_valid;
  logic [PW-1:0]        res_data;
  logic                 res_ready = 1'b0;
  logic                 busy;

  int errors = 0;
  int checks = 0;
  arr_t cref;
  int acc_q;

  filter_mac_sequencer #(
    .KERNEL_TAPS(TAPS), .FRAC_BITS(FRAC), .PIXEL_WIDTH(PW),
    .COEFF_WIDTH(CW), .ACC_WIDTH(AW), .ADDR_WIDTH(ADW)
  ) dut (
    .clk(clk), .nreset(nreset), .enable(enable),
    .coeff_wr_en(coeff_wr_en), .coeff_wr_addr(coeff_wr_addr), .coeff_wr_data(coeff_wr_data),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .mac_pixel(mac_pixel), .mac_coeff(mac_coeff), .mac_en(mac_en), .mac_last(mac_last),
    .mac_result(mac_result), .res_valid(res_valid), .res_data(res_data),
    .res_ready(res_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in for the external MAC: accumulate on enable, publish and clear on last.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      acc_q      <= 0;
      mac_result <= '0;
    end else if (mac_en) begin
      if (mac_last) begin
        mac_result <= acc_q + int'(mac_pixel) * int'($signed(mac_coeff));
        acc_q      <= 0;
      end else begin
        acc_q <= acc_q + int'(mac_pixel) * int'($signed(mac_coeff));
      end
    end
  end

  function automatic int ref_norm(input arr_t pix, input arr_t cf);
    longint sum;
    longint t;
    sum = 0;
    for (int i = 0; i < TAPS; i++) sum += longint'(pix[i]) * longint'(cf[i]);
    t = (sum + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
`ifdef SEQ_ABSOLUTE_EN
    if (t < 0) t = -t;
`else
    if (t < 0) t = 0;
`endif
    if (t > (1 << PW) - 1) t = (1 << PW) - 1;
    return int'(t);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load_coeffs(input arr_t c);
    int n;
    enable = 1'b0;
    n = 0;
    while (busy && n < 50) begin tick(); n++; end
    chk("idle_before_load", busy, 0);
    for (int i = 0; i < TAPS; i++) begin
      coeff_wr_en   = 1'b1;
      coeff_wr_addr = ADW'(i);
      coeff_wr_data = CW'(c[i]);
      tick();
      cref[i] = c[i];
    end
    coeff_wr_addr = ADW'($urandom_range(TAPS, (1 << ADW) - 1));
    coeff_wr_data = CW'(12345);
    tick();
    coeff_wr_en = 1'b0;
  endtask

  // gap_mode: 0 none, 1 one idle cycle before every tap, 2 random idle cycles.
  task automatic run_kernel(input arr_t pix, input int gap_mode, input bit stay,
                            input bit drop_mid, input bit wr_run, input int bp);
    int n;
    int exp;
    exp = ref_norm(pix, cref);
    enable = 1'b1;
    n = 0;
    while (!pix_ready && n < 20) begin tick(); n++; end
    chk("run_entry", pix_ready, 1);
    for (int i = 0; i < TAPS; i++) begin
      if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 1) == 1)) begin
        pix_valid = 1'b0;
        pix_data  = PW'($urandom);
        #1;
        chk("gap_mac_en", mac_en, 0);
        tick();
      end
      pix_valid = 1'b1;
      pix_data  = PW'(pix[i]);
      if (drop_mid && i == 4) enable = 1'b0;
      if (wr_run && i == 2) begin
        coeff_wr_en   = 1'b1;
        coeff_wr_addr = '0;
        coeff_wr_data = CW'(cref[0] + 77);
      end
      #1;
      chk("mac_en", mac_en, 1);
      chk("mac_last", mac_last, (i == TAPS - 1));
      chk("mac_coeff", int'($signed(mac_coeff)), cref[i]);
      chk("mac_pixel", mac_pixel, pix[i]);
      tick();
      coeff_wr_en = 1'b0;
    end
    pix_valid = 1'b0;
    #1;
    chk("wait_res_valid", res_valid, 0);
    chk("wait_pix_ready", pix_ready, 0);
    chk("wait_busy", busy, 1);
    tick();
    chk("res_valid_rise", res_valid, 1);
    chk("res_data", res_data, exp);
    res_ready = 1'b0;
    pix_valid = 1'b1;
    for (int k = 0; k < bp; k++) begin
      chk("bp_res_valid", res_valid, 1);
      chk("bp_res_data", res_data, exp);
      chk("bp_pix_ready", pix_ready, 0);
      chk("bp_mac_en", mac_en, 0);
      tick();
    end
    if (!stay) enable = 1'b0;
    res_ready = 1'b1;
    #1;
    chk("pre_hs_res_valid", res_valid, 1);
    tick();
    res_ready = 1'b0;
    pix_valid = 1'b0;
    chk("post_hs_res_valid", res_valid, 0);
    chk("post_hs_busy", busy, stay);
  endtask

  initial begin
    arr_t c;
    arr_t p;
    int n;

    repeat (2) tick();
    nreset = 1'b1;
    tick();
    pix_valid = 1'b1;
    #1;
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pix_ready", pix_ready, 0);
    chk("rst_mac_en", mac_en, 0);
    chk("rst_mac_last", mac_last, 0);
    pix_valid = 1'b0;

    // Identity kernel
    c = '{default: 0}; c[4] = 1024;
    load_coeffs(c);
    for (int i = 0; i < TAPS; i++) p[i] = 10 * (i + 1);
    run_kernel(p, 0, 1'b0, 1'b0, 1'b0, 0);
    chk("identity_res", res_data, 50);

    // Rounding
    c = '{default: 0}; c[0] = 512;
    load_coeffs(c);
    for (int i = 0; i < TAPS; i++) p[i] = $urandom_range(0, 255);
    p[0] = 3;
    run_kernel(p, 0, 1'b0, 1'b0, 1'b0, 0);
    chk("round_half_up", res_data, 2);
    c = '{default: 114};
    load_coeffs(c);
    p = '{default: 100};
    run_kernel(p, 0, 1'b0, 1'b0, 1'b0, 0);
    chk("round_down", res_data, 100);

    // Saturation
    c = '{default: 1024};
    load_coeffs(c);
    p = '{default: 255};
    run_kernel(p, 0, 1'b0, 1'b0, 1'b0, 0);
    chk("sat_high", res_data, 255);
    c = '{default: 0}; c[0] = -1024;
    load_coeffs(c);
    for (int i = 0; i < TAPS; i++) p[i] = $urandom_range(0, 255);
    p[0] = 50;
    run_kernel(p, 0, 1'b0, 1'b0, 1'b0, 0);
`ifdef SEQ_ABSOLUTE_EN
    chk("sat_negative", res_data, 50);
`else
    chk("sat_negative", res_data, 0);
`endif

    // Backpressure, stalls, write lockout during RUN, enable drop mid-kernel
    for (int i = 0; i < TAPS; i++) c[i] = $urandom_range(0, 400) - 150;
    load_coeffs(c);
    for (int i = 0; i < TAPS; i++) p[i] = $urandom_range(0, 255);
    run_kernel(p, 0, 1'b1, 1'b0, 1'b0, 5);
    for (int i = 0; i < TAPS; i++) p[i] = $urandom_range(0, 255);
    run_kernel(p, 1, 1'b1, 1'b0, 1'b1, 0);
    for (int i = 0; i < TAPS; i++) p[i] = $urandom_range(0, 255);
    run_kernel(p, 0, 1'b0, 1'b1, 1'b0, 1);

    // Reset after four taps
    for (int i = 0; i < TAPS; i++) c[i] = $urandom_range(1, 300);
    load_coeffs(c);
    enable = 1'b1;
    n = 0;
    while (!pix_ready && n < 20) begin tick(); n++; end
    chk("mid_rst_entry", pix_ready, 1);
    for (int i = 0; i < 4; i++) begin
      pix_valid = 1'b1;
      pix_data  = PW'($urandom_range(1, 255));
      tick();
    end
    #2;
    nreset = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pix_ready", pix_ready, 0);
    chk("mid_rst_mac_en", mac_en, 0);
    chk("mid_rst_mac_last", mac_last, 0);
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_res_data", res_data, 0);
    enable    = 1'b0;
    pix_valid = 1'b0;
    tick();
    nreset = 1'b1;
    tick();
    cref = '{default: 0};
    for (int i = 0; i < TAPS; i++) p[i] = $urandom_range(0, 255);
    run_kernel(p, 0, 1'b0, 1'b0, 1'b0, 0);
    load_coeffs(c);
    for (int i = 0; i < TAPS; i++) p[i] = $urandom_range(0, 255);
    run_kernel(p, 2, 1'b0, 1'b0, 1'b0, 2);

    // Randomised kernels
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < TAPS; i++) c[i] = $urandom_range(0, 500) - 200;
      load_coeffs(c);
      for (int i = 0; i < TAPS; i++) p[i] = $urandom_range(0, 255);
      run_kernel(p, 2, 1'b0, 1'b0, 1'b0, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
